// File: rtl/dram_req_sched.sv
// Round-robin DRAM request scheduler: per-port credits, in-order return-info FIFO, read/write completion.
// Optional return-info parity check is enabled by defining DRAM_REQ_SCHED_PARITY_EN.
module dram_req_sched #(
   parameter int NPORT    = 4,
   parameter int RETDEPTH = 16,
   parameter int MAXOUT   = 4,
   parameter int ADDRW    = 27,
   parameter int TIDW     = 6
) (
   input  logic                    gclk,
   input  logic                    rst,
   input  logic [NPORT-1:0]        req_valid,
   input  logic [NPORT-1:0]        req_we,
   output logic [NPORT-1:0]        req_ready,
   input  logic [NPORT*ADDRW-1:0]  req_addr,
   input  logic [NPORT*TIDW-1:0]   req_tid,
   output logic                    af_we,
   output logic [ADDRW-1:0]        af_addr,
   output logic                    af_wr,
   input  logic                    af_full,
   input  logic                    wb_full,
   input  logic                    rb_empty,
   output logic                    rb_re,
   output logic [NPORT-1:0]        rsp_valid,
   output logic [NPORT-1:0]        rsp_done,
   output logic [TIDW-1:0]         rsp_tid,
   output logic                    rsp_write,
   output logic                    luterr
);

   localparam int PW = $clog2(NPORT);
   localparam int AW = $clog2(RETDEPTH);
   localparam int CW = $clog2(MAXOUT + 1);
`ifdef DRAM_REQ_SCHED_PARITY_EN
   localparam int EW = PW + TIDW + 2;
`else
   localparam int EW = PW + TIDW + 1;
`endif
   localparam logic [CW-1:0] MAXOUT_C = CW'(MAXOUT);
   localparam logic [AW:0]   ALMOST_C = (AW+1)'(RETDEPTH - 2);

   logic             en;
   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    gnt_idx;
   logic             gnt_any;
   logic [NPORT-1:0] elig;
   logic [CW-1:0]    credit [NPORT];
   int               scan_idx;

   logic [EW-1:0]    ret_mem [RETDEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      ret_cnt;
   logic             ret_almost_full;
   logic [EW-1:0]    push_ent;
   logic [EW-1:0]    head_ent;
   logic             head_valid;
   logic             head_we;
   logic [TIDW-1:0]  head_tid;
   logic [PW-1:0]    head_port;
   logic             head_seen;
   logic             pop_wr;
   logic             pop;

   always_comb begin
      for (int i = 0; i < NPORT; i++)
         elig[i] = req_valid[i] & en & (credit[i] < MAXOUT_C);
   end

   // Scan from rr_ptr upward with wrap; first eligible port wins.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_idx = 0;
      for (int k = 0; k < NPORT; k++) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= NPORT)
            scan_idx = scan_idx - NPORT;
         if (!gnt_any && elig[scan_idx[PW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx[PW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (gnt_any)
         req_ready[gnt_idx] = 1'b1;
   end

`ifdef DRAM_REQ_SCHED_PARITY_EN
   assign push_ent = {^{gnt_idx, req_tid[gnt_idx*TIDW +: TIDW], req_we[gnt_idx]},
                      gnt_idx, req_tid[gnt_idx*TIDW +: TIDW], req_we[gnt_idx]};
`else
   assign push_ent = {gnt_idx, req_tid[gnt_idx*TIDW +: TIDW], req_we[gnt_idx]};
`endif

   assign head_ent        = ret_mem[rd_ptr];
   assign head_we         = head_ent[0];
   assign head_tid        = head_ent[TIDW:1];
   assign head_port       = head_ent[PW+TIDW:TIDW+1];
   assign head_valid      = (ret_cnt != '0);
   assign ret_almost_full = (ret_cnt >= ALMOST_C);
   assign rb_re           = head_valid & ~head_we & ~rb_empty;
   // Writes need no read data; they retire after sitting one cycle at the head.
   assign pop_wr          = head_valid & head_we & head_seen;
   assign pop             = rb_re | pop_wr;

   always_ff @(posedge gclk) begin
      if (!rst && gnt_any)
         ret_mem[wr_ptr] <= push_ent;
   end

   always_ff @(posedge gclk) begin
      if (rst) begin
         en        <= 1'b0;
         rr_ptr    <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ret_cnt   <= '0;
         head_seen <= 1'b0;
         af_we     <= 1'b0;
         af_addr   <= '0;
         af_wr     <= 1'b0;
         rsp_valid <= '0;
         rsp_done  <= '0;
         rsp_tid   <= '0;
         rsp_write <= 1'b0;
      end else begin
         en    <= ~af_full & ~wb_full & ~ret_almost_full;
         af_we <= gnt_any;
         if (gnt_any) begin
            af_addr <= req_addr[gnt_idx*ADDRW +: ADDRW];
            af_wr   <= req_we[gnt_idx];
            rr_ptr  <= (gnt_idx == PW'(NPORT - 1)) ? '0 : gnt_idx + 1'b1;
            wr_ptr  <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({gnt_any, pop})
            2'b10:   ret_cnt <= ret_cnt + 1'b1;
            2'b01:   ret_cnt <= ret_cnt - 1'b1;
            default: ret_cnt <= ret_cnt;
         endcase
         head_seen <= head_valid & head_we & ~head_seen;
         rsp_valid <= '0;
         rsp_done  <= '0;
         if (pop)
            rsp_done[head_port] <= 1'b1;
         if (rb_re)
            rsp_valid[head_port] <= 1'b1;
         rsp_tid   <= pop ? head_tid : '0;
         rsp_write <= pop_wr;
      end
   end

   for (genvar gi = 0; gi < NPORT; gi++) begin : g_credit
      logic inc;
      logic dec;
      assign inc = gnt_any && (gnt_idx == PW'(gi));
      assign dec = pop && (head_port == PW'(gi));
      always_ff @(posedge gclk) begin
         if (rst)
            credit[gi] <= '0;
         else if (inc && !dec)
            credit[gi] <= credit[gi] + 1'b1;
         else if (dec && !inc)
            credit[gi] <= credit[gi] - 1'b1;
      end
   end

`ifdef DRAM_REQ_SCHED_PARITY_EN
   logic luterr_q;
   // Stored parity makes the XOR over a whole intact entry zero.
   always_ff @(posedge gclk) begin
      if (rst)
         luterr_q <= 1'b0;
      else if (pop && (^head_ent))
         luterr_q <= 1'b1;
   end
   assign luterr = luterr_q;
`else
   assign luterr = 1'b0;
`endif

endmodule

// File: tb/tb_dram_req_sched.sv
// Bench for dram_req_sched: arbitration vector table, scoreboarded command/response checks,
// and directed sequences for write/read completion, credits, FIFO limit and mid-run reset.
module tb_dram_req_sched;
   localparam int NPORT    = 4;
   localparam int RETDEPTH = 16;
   localparam int MAXOUT   = 4;
   localparam int ADDRW    = 27;
   localparam int TIDW     = 6;

   logic                   gclk;
   logic                   rst;
   logic [NPORT-1:0]       req_valid;
   logic [NPORT-1:0]       req_we;
   logic [NPORT-1:0]       req_ready;
   logic [NPORT*ADDRW-1:0] req_addr;
   logic [NPORT*TIDW-1:0]  req_tid;
   logic                   af_we;
   logic [ADDRW-1:0]       af_addr;
   logic                   af_wr;
   logic                   af_full;
   logic                   wb_full;
   logic                   rb_empty;
   logic                   rb_re;
   logic [NPORT-1:0]       rsp_valid;
   logic [NPORT-1:0]       rsp_done;
   logic [TIDW-1:0]        rsp_tid;
   logic                   rsp_write;
   logic                   luterr;

   dram_req_sched #(
      .NPORT(NPORT), .RETDEPTH(RETDEPTH), .MAXOUT(MAXOUT), .ADDRW(ADDRW), .TIDW(TIDW)
   ) dut (
      .gclk(gclk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_ready(req_ready),
      .req_addr(req_addr), .req_tid(req_tid),
      .af_we(af_we), .af_addr(af_addr), .af_wr(af_wr),
      .af_full(af_full), .wb_full(wb_full),
      .rb_empty(rb_empty), .rb_re(rb_re),
      .rsp_valid(rsp_valid), .rsp_done(rsp_done), .rsp_tid(rsp_tid), .rsp_write(rsp_write),
      .luterr(luterr)
   );

   initial gclk = 1'b0;
   always #5 gclk = ~gclk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge gclk);
      #1;
   endtask

   typedef struct {
      logic [ADDRW-1:0] addr;
      logic             wr;
   } af_exp_t;

   typedef struct {
      int              port;
      logic [TIDW-1:0] tid;
      logic            we;
   } rsp_exp_t;

   af_exp_t  af_q[$];
   rsp_exp_t rsp_q[$];
   af_exp_t  mon_af;
   rsp_exp_t mon_rsp;

   // Scoreboard: grants push expectations, DUT command/response outputs pop and compare.
   always @(negedge gclk) begin
      if (!rst) begin
         if (rsp_done != '0) begin
            if (rsp_q.size() == 0)
               chk("rsp_unexpected", 64'(rsp_done), 64'd0);
            else begin
               mon_rsp = rsp_q.pop_front();
               chk("rsp_done", 64'(rsp_done), 64'd1 << mon_rsp.port);
               chk("rsp_valid", 64'(rsp_valid), mon_rsp.we ? 64'd0 : (64'd1 << mon_rsp.port));
               chk("rsp_tid", 64'(rsp_tid), 64'(mon_rsp.tid));
               chk("rsp_write", 64'(rsp_write), 64'(mon_rsp.we));
            end
         end else if (rsp_valid != '0 || rsp_write)
            chk("rsp_stray", 64'({rsp_valid, rsp_write}), 64'd0);
         if (rb_re) begin
            chk("rb_re_while_empty", 64'(rb_empty), 64'd0);
            chk("rb_re_head_is_read", 64'(rsp_q.size() != 0 && !rsp_q[0].we), 64'd1);
         end
         if (af_we) begin
            if (af_q.size() == 0)
               chk("af_unexpected", 64'(af_we), 64'd0);
            else begin
               mon_af = af_q.pop_front();
               chk("af_addr", 64'(af_addr), 64'(mon_af.addr));
               chk("af_wr", 64'(af_wr), 64'(mon_af.wr));
            end
         end
         if (req_ready != '0)
            chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
         for (int p = 0; p < NPORT; p++) begin
            if (req_valid[p] && req_ready[p]) begin
               af_q.push_back('{addr: req_addr[p*ADDRW +: ADDRW], wr: req_we[p]});
               rsp_q.push_back('{port: p, tid: req_tid[p*TIDW +: TIDW], we: req_we[p]});
            end
         end
      end
   end

   task automatic set_port(input int p, input logic v, input logic we,
                           input logic [TIDW-1:0] tid, input logic [ADDRW-1:0] addr);
      req_valid[p]               = v;
      req_we[p]                  = we;
      req_tid[p*TIDW +: TIDW]    = tid;
      req_addr[p*ADDRW +: ADDRW] = addr;
   endtask

   task automatic drain();
      bit done;
      done     = 1'b0;
      rb_empty = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         tick();
         @(negedge gclk);
         if (rsp_q.size() == 0 && af_q.size() == 0)
            done = 1'b1;
      end
      chk("drain_left", 64'(rsp_q.size()), 64'd0);
      tick();
   endtask

   typedef struct {
      logic [NPORT-1:0] valid;
      logic             af;
      logic [NPORT-1:0] exp_ready;
   } arb_vec_t;

   arb_vec_t vec[15];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int late;
      bit rose;

      vec[0]  = '{4'b1111, 1'b0, 4'b0001};
      vec[1]  = '{4'b1111, 1'b0, 4'b0010};
      vec[2]  = '{4'b1111, 1'b0, 4'b0100};
      vec[3]  = '{4'b1111, 1'b0, 4'b1000};
      vec[4]  = '{4'b1111, 1'b0, 4'b0001};
      vec[5]  = '{4'b0101, 1'b0, 4'b0100};
      vec[6]  = '{4'b0101, 1'b0, 4'b0001};
      vec[7]  = '{4'b1000, 1'b0, 4'b1000};
      vec[8]  = '{4'b0000, 1'b0, 4'b0000};
      vec[9]  = '{4'b0110, 1'b1, 4'b0010};
      vec[10] = '{4'b0110, 1'b1, 4'b0000};
      vec[11] = '{4'b0110, 1'b0, 4'b0000};
      vec[12] = '{4'b0110, 1'b0, 4'b0100};
      vec[13] = '{4'b0110, 1'b0, 4'b0010};
      vec[14] = '{4'b0000, 1'b0, 4'b0000};

      rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_tid = '0;
      af_full = 1'b0; wb_full = 1'b0; rb_empty = 1'b1;
      repeat (3) tick();
      @(negedge gclk);
      chk("rst_af_we", 64'(af_we), 64'd0);
      chk("rst_rb_re", 64'(rb_re), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_done", 64'(rsp_done), 64'd0);
      chk("rst_rsp_write", 64'(rsp_write), 64'd0);
      chk("rst_luterr", 64'(luterr), 64'd0);
      tick(); rst = 1'b0;
      repeat (3) tick();

      rb_empty = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         af_full = vec[i].af;
         for (int p = 0; p < NPORT; p++)
            set_port(p, vec[i].valid[p], 1'b0, TIDW'(i * 4 + p), ADDRW'((i << 8) | (p << 4) | 3));
         @(negedge gclk);
         chk($sformatf("arb_row%0d", i), 64'(req_ready), 64'(vec[i].exp_ready));
      end
      tick(); req_valid = '0; af_full = 1'b0;
      drain();

      // Write from port 1: command next cycle, completion two cycles after that, no rb pop.
      tick();
      set_port(1, 1'b1, 1'b1, 6'd5, 27'h12345);
      @(negedge gclk);
      chk("wr_ready", 64'(req_ready), 64'b0010);
      tick(); req_valid = '0;
      @(negedge gclk);
      chk("wr_af_we", 64'(af_we), 64'd1);
      chk("wr_af_wr", 64'(af_wr), 64'd1);
      chk("wr_rb_re_c1", 64'(rb_re), 64'd0);
      tick();
      @(negedge gclk);
      chk("wr_rsp_early", 64'(rsp_done), 64'd0);
      chk("wr_rb_re_c2", 64'(rb_re), 64'd0);
      tick();
      @(negedge gclk);
      chk("wr_rsp_done", 64'(rsp_done), 64'b0010);
      chk("wr_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("wr_rsp_write", 64'(rsp_write), 64'd1);
      drain();

      // Read from port 3 waiting on rb_empty for 10 cycles.
      rb_empty = 1'b1;
      tick();
      set_port(3, 1'b1, 1'b0, 6'h2A, 27'h7ABCDE);
      @(negedge gclk);
      chk("rd_ready", 64'(req_ready), 64'b1000);
      tick(); req_valid = '0;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         @(negedge gclk);
         if (rb_re) n++;
      end
      chk("rd_rb_re_while_empty", 64'(n), 64'd0);
      tick(); rb_empty = 1'b0;
      @(negedge gclk);
      chk("rd_rb_re", 64'(rb_re), 64'd1);
      tick(); rb_empty = 1'b1;
      @(negedge gclk);
      chk("rd_rsp_valid", 64'(rsp_valid), 64'b1000);
      chk("rd_rsp_tid", 64'(rsp_tid), 64'h2A);
      chk("rd_rsp_write", 64'(rsp_write), 64'd0);
      chk("rd_rb_re_once", 64'(rb_re), 64'd0);
      drain();

      // Port 2 credit limit.
      rb_empty = 1'b1;
      tick();
      set_port(2, 1'b1, 1'b0, 6'd9, 27'h222);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge gclk);
         if (req_ready[2]) n++;
         tick();
      end
      chk("credit_cap_grants", 64'(n), 64'(MAXOUT));
      @(negedge gclk);
      chk("credit_stall", 64'(req_ready[2]), 64'd0);
      tick(); rb_empty = 1'b0;
      @(negedge gclk);
      chk("credit_pop", 64'(rb_re), 64'd1);
      tick(); rb_empty = 1'b1;
      rose = 1'b0;
      for (int k = 0; k < 2 && !rose; k++) begin
         @(negedge gclk);
         if (req_ready[2]) rose = 1'b1;
         else tick();
      end
      chk("credit_release", 64'(rose), 64'd1);
      tick(); req_valid = '0;
      drain();

      // Return-info FIFO limit with all ports reading and no read data returning.
      rb_empty = 1'b1;
      tick();
      for (int p = 0; p < NPORT; p++)
         set_port(p, 1'b1, 1'b0, TIDW'(p + 16), ADDRW'(p + 27'h400));
      n = 0; late = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge gclk);
         if (req_ready != '0) begin
            n++;
            if (k >= 20) late++;
         end
         tick();
      end
      chk("fifo_limit_range", 64'(n >= RETDEPTH - 2 && n <= RETDEPTH - 1), 64'd1);
      chk("fifo_late_grants", 64'(late), 64'd0);
      req_valid = '0;
      drain();

      // Mixed random traffic, ordering checked by the scoreboard.
      for (int k = 0; k < 60; k++) begin
         tick();
         rb_empty = 1'($urandom_range(0, 1));
         for (int p = 0; p < NPORT; p++)
            set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     TIDW'($urandom), ADDRW'($urandom));
      end
      tick(); req_valid = '0;
      drain();

      // Reset with entries in flight: none of them may complete afterwards.
      rb_empty = 1'b1;
      tick();
      set_port(0, 1'b1, 1'b0, 6'd1, 27'h11);
      set_port(1, 1'b1, 1'b0, 6'd2, 27'h22);
      repeat (3) tick();
      req_valid = '0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; af_q.delete(); rsp_q.delete();
      @(negedge gclk);
      chk("rst_mid_af_we", 64'(af_we), 64'd0);
      chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
      chk("rst_mid_rsp_done", 64'(rsp_done), 64'd0);
      tick(); rb_empty = 1'b0;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge gclk);
         if (rb_re || rsp_done != '0) n++;
         tick();
      end
      chk("rst_mid_no_rsp", 64'(n), 64'd0);

`ifdef DRAM_REQ_SCHED_PARITY_EN
      rb_empty = 1'b1;
      tick();
      set_port(0, 1'b1, 1'b0, 6'h15, 27'h55);
      tick(); req_valid = '0;
      repeat (2) tick();
      dut.ret_mem[dut.rd_ptr][dut.EW-1] = ~dut.ret_mem[dut.rd_ptr][dut.EW-1];
      drain();
      @(negedge gclk);
      chk("par_luterr_set", 64'(luterr), 64'd1);
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      @(negedge gclk);
      chk("par_luterr_clr", 64'(luterr), 64'd0);
`else
      @(negedge gclk);
      chk("luterr_tied", 64'(luterr), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dram_req_sched.md
DRAM_REQ_SCHED -- requirements
Module: dram_req_sched

Interface
REQ-001 Parameter NPORT, default 4: number of requestor ports; valid range 2..16.
REQ-002 Parameter RETDEPTH, default 16: return-info FIFO depth; power of two, at least 4.
REQ-003 Parameter MAXOUT, default 4: maximum outstanding transactions per port, at least 1.
REQ-004 Parameter ADDRW, default 27: line address width. Parameter TIDW, default 6: thread-ID width.
REQ-005 Port gclk, input, 1: clock; reset rst, synchronous, active-high; clock gclk.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Ports req_valid, req_we (input, NPORT each) and req_ready (output, NPORT): per-port request handshake; req_we set means write.
REQ-008 Ports req_addr (input, NPORT*ADDRW) and req_tid (input, NPORT*TIDW): per-port request fields; port i occupies slice i.
REQ-009 Ports af_we (output, 1), af_addr (output, ADDRW) and af_wr (output, 1): command push to the memory controller address FIFO.
REQ-010 Ports af_full and wb_full (input, 1 each): memory controller address-FIFO and write-buffer full flags.
REQ-011 Ports rb_empty (input, 1) and rb_re (output, 1): memory controller read-return buffer status and pop.
REQ-012 Ports rsp_valid and rsp_done (output, NPORT each), rsp_tid (output, TIDW) and rsp_write (output, 1): per-port completion.
REQ-013 Port luterr, output, 1: sticky return-info parity error flag.

Function
REQ-014 Issue enable en is a register: ~af_full & ~wb_full & ~ret_almost_full, sampled every cycle.
REQ-015 Port i is eligible when req_valid[i]=1, en=1 and credit[i]<MAXOUT.
REQ-016 At most one grant per cycle, round-robin: search starts at port (last granted + 1) mod NPORT; the pointer resets to port 0.
REQ-017 req_ready[i] is asserted combinationally only for the granted port; the request transfers on req_valid & req_ready.
REQ-018 One cycle after a grant: af_we=1, af_addr/af_wr carry the granted request's fields, and an entry {port id, tid, we} is pushed into the return-info FIFO.
REQ-019 ret_almost_full is set when occupancy is at least RETDEPTH-2, so the FIFO never overflows given the registered enable.
REQ-020 A write head entry pops one cycle after becoming head; the following cycle rsp_done[port]=1, rsp_valid=0 and rsp_write=1.
REQ-021 A read head entry: rb_re=1 exactly when the head is valid, is a read and rb_empty=0; the pop occurs in the same cycle.
REQ-022 The cycle after a read pop: rsp_valid[port]=rsp_done[port]=1, rsp_tid=entry tid and rsp_write=0; all other bits are 0.
REQ-023 rb_re is never asserted while the FIFO is empty or the head is a write; a push into an empty FIFO becomes head the next cycle.
REQ-024 credit[i] increments on grant and decrements on retire; both in the same cycle leaves it unchanged; saturation is prevented by REQ-015.
REQ-025 Completions retire strictly in issue order; rsp outputs are single-cycle pulses.

Reset
REQ-026 On rst: FIFO emptied, credits 0, RR pointer 0, en 0, luterr 0; af_we, rb_re, req_ready, rsp_valid, rsp_done and rsp_write are all 0 the next cycle.
REQ-027 Reset mid-operation discards all in-flight entries, and no response is emitted for them.

Configuration
REQ-028 Macro DRAM_REQ_SCHED_PARITY_EN defined: each FIFO entry stores even parity over {we, tid, port id}, and a mismatch at pop sets luterr until rst.
REQ-029 Macro undefined: no parity bit is stored and luterr is tied to 0.

Verification
REQ-030 NPORT=4, all ports request reads continuously, en=1 -> grants cycle 0,1,2,3,0; one af_we per cycle.
REQ-031 Port 2 issues MAXOUT=4 reads with rb_empty=1 -> fifth request stalls with req_ready[2]=0; after one rb pop, req_ready[2] rises within 2 cycles.
REQ-032 Write from port 1 with tid=5 -> af_we, af_wr=1; two cycles later rsp_done[1]=1, rsp_valid=0, rsp_write=1, rb_re never asserted.
REQ-033 Read from port 3 with tid=0x2A, rb_empty drops 10 cycles later -> rb_re=1 for one cycle; next cycle rsp_valid[3]=1 and rsp_tid=0x2A.
REQ-034 af_full=1 held -> no grants from the cycle after assertion; RETDEPTH-2 outstanding reads -> grants stop, no overflow.
REQ-035 With parity enabled, force a flipped entry bit -> luterr=1 after its pop; rst clears it.
